red_pitaya_pwm: RTL and testbench



---
 rtl/red_pitaya_pwm.sv | 81 ++++++++
 tb/tb_red_pitaya_pwm.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/red_pitaya_pwm.sv
// ---------------------------------------------------------------------------
// red_pitaya_pwm
//
// Turns a 24-bit slow-DAC configuration word into a 1-bit PWM stream for
// the RC reconstruction filter. The upper byte sets a base duty V.
// The lower 16 bits select, per sub-period of a 16-sub-period frame,
// whether that sub-period gets one extra high clock. This dithering yields
// 12-bit effective resolution.
//
// The configuration is shadowed and only reloaded on the last clock of a
// frame. A change on cfg_i therefore never glitches the current frame.
//
// Parameters:
//   FULL     sub-period length in clocks (2..255); cnt runs 0..FULL-1
//
// Ports:
//   clk_i    clock
//   rstn_i   asynchronous active-low reset
//   cfg_i    configuration word: [23:16] base duty V, [15:0] dither pattern P
//   pwm_o    registered PWM output
//   frame_o  one-clock pulse in the cycle the shadow configuration is reloaded
//   cfg_q_o  active shadow configuration (readback/debug)
// ---------------------------------------------------------------------------
module red_pitaya_pwm #(
    parameter int unsigned FULL = 255
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic [23:0] cfg_i,
    output logic        pwm_o,
    output logic        frame_o,
    output logic [23:0] cfg_q_o
);

    localparam logic [7:0] CntMax = 8'(FULL - 1);

    logic [7:0]  cnt_q, cnt_d;
    logic [3:0]  bcnt_q, bcnt_d;
    logic [23:0] cfg_q, cfg_d;
    logic        pwm_q, pwm_d;
    logic        frame_q, frame_d;

    logic        cnt_wrap;
    logic        frame_end;
    logic [8:0]  duty;

    always_comb begin
        cnt_wrap  = (cnt_q == CntMax);
        frame_end = cnt_wrap && (bcnt_q == 4'hF);

        // 9-bit sum so V=255 plus a dither bit does not wrap back to a low duty
        duty = {1'b0, cfg_q[23:16]} + {8'd0, cfg_q[bcnt_q]};

        cnt_d   = cnt_wrap ? 8'd0 : cnt_q + 8'd1;
        bcnt_d  = cnt_wrap ? bcnt_q + 4'd1 : bcnt_q;
        cfg_d   = frame_end ? cfg_i : cfg_q;
        pwm_d   = ({1'b0, cnt_q} < duty);
        frame_d = frame_end;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt_q   <= 8'd0;
            bcnt_q  <= 4'd0;
            cfg_q   <= 24'h0;
            pwm_q   <= 1'b0;
            frame_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            bcnt_q  <= bcnt_d;
            cfg_q   <= cfg_d;
            pwm_q   <= pwm_d;
            frame_q <= frame_d;
        end
    end

    assign pwm_o   = pwm_q;
    assign frame_o = frame_q;
    assign cfg_q_o = cfg_q;

endmodule

// File: tb/tb_red_pitaya_pwm.sv
// ---------------------------------------------------------------------------
// tb_red_pitaya_pwm
//
// Two instances share clock and reset: u0 with FULL=255, u1 with FULL=4.
// A reference model derives each instance's expected outputs from the
// elapsed clock count since reset and the frame-boundary reload rule.
// It pushes them into per-instance queues. A monitor pops and compares
// on the falling edge. Per-frame high-clock totals are also checked
// against sum(min(V + P[s], FULL)).
// ---------------------------------------------------------------------------
module tb_red_pitaya_pwm;

    logic        clk;
    logic        rstn;
    logic [23:0] cfg_in [2];
    logic        pwm    [2];
    logic        frm    [2];
    logic [23:0] cfg_q  [2];

    int          full   [2];
    int          n_chk;
    int          n_pass;

    // reference model state
    int          m_k    [2];
    logic [23:0] m_cfg  [2];
    logic [25:0] q0 [$];
    logic [25:0] q1 [$];

    // monitor-side frame accounting
    int          acc     [2];
    logic [23:0] act_cfg [2];

    red_pitaya_pwm #(.FULL(255)) u0 (
        .clk_i   (clk),
        .rstn_i  (rstn),
        .cfg_i   (cfg_in[0]),
        .pwm_o   (pwm[0]),
        .frame_o (frm[0]),
        .cfg_q_o (cfg_q[0])
    );

    red_pitaya_pwm #(.FULL(4)) u1 (
        .clk_i   (clk),
        .rstn_i  (rstn),
        .cfg_i   (cfg_in[1]),
        .pwm_o   (pwm[1]),
        .frame_o (frm[1]),
        .cfg_q_o (cfg_q[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // High clocks in one frame: each sub-period is high for min(duty, FULL) clocks
    function automatic int frame_highs(input logic [23:0] c, input int f);
        int sum;
        int d;
        sum = 0;
        for (int s = 0; s < 16; s++) begin
            d = int'(c[23:16]) + int'(c[s]);
            sum += (d < f) ? d : f;
        end
        return sum;
    endfunction

    // Reference model: position from elapsed clocks, reload on the last clock of a frame
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 2; i++) begin
                m_k[i]   = 0;
                m_cfg[i] = 24'h0;
            end
            q0.delete();
            q1.delete();
        end else begin
            for (int i = 0; i < 2; i++) begin
                int          pos;
                int          sub;
                int          duty;
                logic        fe;
                logic [23:0] nc;
                logic [25:0] e;
                pos  = m_k[i] % full[i];
                sub  = (m_k[i] / full[i]) % 16;
                duty = int'(m_cfg[i][23:16]) + int'(m_cfg[i][sub]);
                fe   = (pos == full[i] - 1) && (sub == 15);
                nc   = fe ? cfg_in[i] : m_cfg[i];
                e    = {(pos < duty), fe, nc};
                if (i == 0) q0.push_back(e);
                else q1.push_back(e);
                m_k[i]   = m_k[i] + 1;
                m_cfg[i] = nc;
            end
        end
    end

    task automatic mon(input int i, input logic [25:0] e);
        chk($sformatf("pwm_o[u%0d]", i), int'(pwm[i]), int'(e[25]));
        chk($sformatf("frame_o[u%0d]", i), int'(frm[i]), int'(e[24]));
        chk($sformatf("cfg_q_o[u%0d]", i), int'(cfg_q[i]), int'(e[23:0]));
        acc[i] += int'(pwm[i]);
        if (e[24]) begin
            chk($sformatf("frame_highs[u%0d]", i), acc[i], frame_highs(act_cfg[i], full[i]));
            acc[i]     = 0;
            act_cfg[i] = e[23:0];
        end
    endtask

    always @(negedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < 2; i++) begin
                acc[i]     = 0;
                act_cfg[i] = 24'h0;
            end
        end else begin
            if (q0.size() > 0) mon(0, q0.pop_front());
            if (q1.size() > 0) mon(1, q1.pop_front());
        end
    end

    task automatic check_zero(input string tag);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%s pwm_o[u%0d]", tag, i), int'(pwm[i]), 0);
            chk($sformatf("%s frame_o[u%0d]", tag, i), int'(frm[i]), 0);
            chk($sformatf("%s cfg_q_o[u%0d]", tag, i), int'(cfg_q[i]), 0);
        end
    endtask

    initial begin
        bit found;
        full[0]   = 255;
        full[1]   = 4;
        n_chk     = 0;
        n_pass    = 0;
        rstn      = 1'b0;
        cfg_in[0] = 24'h0F_0000;
        cfg_in[1] = 24'h02_AAAA;
        #3;
        check_zero("reset");
        #19 rstn = 1'b1;

        // Base duty only, then one dither bit, then the saturating extremes
        repeat (2 * 4080) @(negedge clk);
        cfg_in[0] = 24'h0F_0001;
        repeat (2 * 4080) @(negedge clk);
        cfg_in[0] = 24'hFF_FFFF;
        cfg_in[1] = 24'hFF_FFFF;
        repeat (6000) @(negedge clk);
        cfg_in[0] = 24'h00_0000;
        cfg_in[1] = 24'h00_0000;
        repeat (6000) @(negedge clk);

        // Mid-frame change must not take effect until the next boundary
        cfg_in[0] = 24'h4E_0000;
        cfg_in[1] = 24'h02_AAAA;
        repeat (4080) @(negedge clk);
        found = 1'b0;
        for (int n = 0; n < 5000 && !found; n++) begin
            @(negedge clk);
            if ((m_k[0] % 255) == 100 && ((m_k[0] / 255) % 16) == 5) found = 1'b1;
        end
        chk("wait_bcnt5_cnt100", int'(found), 1);
        cfg_in[0] = 24'h9C_0000;
        repeat (2 * 4080) @(negedge clk);

        // Randomised configuration changes at arbitrary times
        for (int r = 0; r < 8; r++) begin
            cfg_in[0] = 24'($urandom);
            cfg_in[1] = 24'($urandom);
            repeat ($urandom_range(200, 2000)) @(negedge clk);
        end

        // Asynchronous reset while pwm_o is high, between clock edges
        cfg_in[0] = 24'h80_0000;
        found = 1'b0;
        for (int n = 0; n < 3 * 4080 && !found; n++) begin
            @(negedge clk);
            if (pwm[0]) found = 1'b1;
        end
        chk("wait_pwm_high", int'(found), 1);
        @(posedge clk);
        #2 rstn = 1'b0;
        #1;
        check_zero("async_reset");
        #20;
        @(posedge clk);
        #2 rstn = 1'b1;
        cfg_in[0] = 24'($urandom);
        cfg_in[1] = 24'($urandom);
        repeat (4080 + 600) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
